// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button conditioner signal bundle (raw inputs, debounced levels, edge pulses)
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  // Driver of raw buttons / consumer of conditioned outputs
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  // The conditioner itself
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchroniser, debouncer and press/release pulse generator; optional auto-repeat under `BTN_AUTOREPEAT_EN
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic                clk,
  input  logic                rst_n,
  button_conditioner_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  // rep_q marks that the first (long) repeat delay has elapsed for the channel
  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];
  logic [N_BTN-1:0]  rep_q, rep_d;
`endif

  // Next-state: synchroniser shift, debounce window per channel, edge pulses (and auto-repeat)
  always_comb begin
    s1_d      = bus.btn_raw;
    s2_d      = s1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
`ifdef BTN_AUTOREPEAT_EN
    hold_d    = hold_q;
    rep_d     = rep_q;
`endif
    for (int ch = 0; ch < N_BTN; ch++) begin
      if (s2_q[ch] == level_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_MAX) begin
        cnt_d[ch]     = '0;
        level_d[ch]   = s2_q[ch];
        press_d[ch]   = s2_q[ch];
        release_d[ch] = ~s2_q[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
      end
`ifdef BTN_AUTOREPEAT_EN
      // Hold timing restarts on every accepted edge and idles while released
      if ((level_d[ch] != level_q[ch]) || !level_q[ch]) begin
        hold_d[ch] = '0;
        rep_d[ch]  = 1'b0;
      end else if (!rep_q[ch] && (hold_q[ch] == DELAY_LAST)) begin
        press_d[ch] = 1'b1;
        hold_d[ch]  = '0;
        rep_d[ch]   = 1'b1;
      end else if (rep_q[ch] && (hold_q[ch] == PERIOD_LAST)) begin
        press_d[ch] = 1'b1;
        hold_d[ch]  = '0;
      end else begin
        hold_d[ch] = hold_q[ch] + HOLD_ONE;
      end
`endif
    end
  end

  // State registers; reset clears everything so a held button must debounce afresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int ch = 0; ch < N_BTN; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Auto-repeat hold counters and phase flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
      for (int ch = 0; ch < N_BTN; ch++) begin
        hold_q[ch] <= '0;
      end
    end else begin
      rep_q  <= rep_d;
      hold_q <= hold_d;
    end
  end
`endif

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard-driven directed bench for button_conditioner
module tb_button_conditioner;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk;
  logic rst_n;

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  task automatic push(input int n, input logic [3:0] l, input logic [3:0] p,
                      input logic [3:0] r, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.lvl = l; e.prs = p; e.rel = r; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic check_now(input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input string tag);
    tests_run++;
    assert ({bus.btn_level, bus.btn_press, bus.btn_release} === {l, p, r}) else begin
      tests_failed++;
      $error("FAIL %s: level=%h press=%h release=%h expected level=%h press=%h release=%h",
             tag, bus.btn_level, bus.btn_press, bus.btn_release, l, p, r);
    end
  endtask

  // Advance n clock edges, comparing DUT outputs to the scoreboard after each edge
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      assert (sb.size() != 0) else begin
        tests_failed++;
        $error("FAIL sb_empty: queue size=%0d expected nonzero", sb.size());
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests_run--;
        check_now(e.lvl, e.prs, e.rel, e.tag);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.btn_raw = '0;
    @(negedge clk);

    // Reset asserted with all buttons held: outputs clear asynchronously
    bus.btn_raw = 4'hF;
    rst_n       = 1'b0;
    #1;
    check_now(4'h0, 4'h0, 4'h0, "reset_async");
    push(3, 4'h0, 4'h0, 4'h0, "reset_hold");
    run(3);
    rst_n = 1'b1;
    push(5, 4'h0, 4'h0, 4'h0, "reset_rel_wait");
    push(1, 4'hF, 4'hF, 4'h0, "reset_rel_edge6");
    run(6);
    bus.btn_raw = 4'h0;
    push(5, 4'hF, 4'h0, 4'h0, "all_release_wait");
    push(1, 4'h0, 4'h0, 4'hF, "all_release_edge6");
    push(2, 4'h0, 4'h0, 4'h0, "idle_a");
    run(8);

    // Clean press on ch0 held for 30 edges, then released
    bus.btn_raw = 4'b0001;
    for (int k = 1; k <= 36; k++) begin
      logic l, p, r;
      l = (k >= 6) && (k < 36);
      p = (k == 6) || (AR && (k >= 16) && (k < 36) && (((k - 16) % 3) == 0));
      r = (k == 36);
      push(1, {3'b000, l}, {3'b000, p}, {3'b000, r}, $sformatf("ch0_hold_e%0d", k));
    end
    run(30);
    bus.btn_raw = 4'b0000;
    run(6);
    push(2, 4'h0, 4'h0, 4'h0, "idle_b");
    run(2);

    // Bounce on ch1: 3 high / 1 low, five times, never accepted
    for (int rep = 0; rep < 5; rep++) begin
      bus.btn_raw = 4'b0010;
      push(3, 4'h0, 4'h0, 4'h0, $sformatf("bounce_hi_%0d", rep));
      run(3);
      bus.btn_raw = 4'b0000;
      push(1, 4'h0, 4'h0, 4'h0, $sformatf("bounce_lo_%0d", rep));
      run(1);
    end
    push(6, 4'h0, 4'h0, 4'h0, "bounce_tail");
    run(6);

    // Simultaneous: ch2 rises while ch3 falls
    bus.btn_raw = 4'b1000;
    push(5, 4'h0, 4'h0, 4'h0, "ch3_rise_wait");
    push(1, 4'h8, 4'h8, 4'h0, "ch3_rise_edge6");
    run(6);
    bus.btn_raw = 4'b0100;
    push(5, 4'h8, 4'h0, 4'h0, "swap_wait");
    push(1, 4'h4, 4'h4, 4'h8, "swap_edge6");
    run(6);
    bus.btn_raw = 4'b0000;
    push(5, 4'h4, 4'h0, 4'h0, "ch2_fall_wait");
    push(1, 4'h0, 4'h0, 4'h4, "ch2_fall_edge6");
    push(2, 4'h0, 4'h0, 4'h0, "idle_c");
    run(8);

    // Reset in the middle of a debounce window discards the pending press
    bus.btn_raw = 4'b0001;
    push(3, 4'h0, 4'h0, 4'h0, "mid_pre");
    run(3);
    rst_n = 1'b0;
    #1;
    check_now(4'h0, 4'h0, 4'h0, "mid_reset_async");
    push(1, 4'h0, 4'h0, 4'h0, "mid_in_reset");
    run(1);
    rst_n = 1'b1;
    push(5, 4'h0, 4'h0, 4'h0, "mid_rel_wait");
    push(1, 4'h1, 4'h1, 4'h0, "mid_rel_edge6");
    run(6);
    bus.btn_raw = 4'b0000;
    push(5, 4'h1, 4'h0, 4'h0, "mid_fall_wait");
    push(1, 4'h0, 4'h0, 4'h1, "mid_fall_edge6");
    run(6);

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL sb_drain: leftover=%0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
